// File: rtl/polar_arbiter.sv
// ---------------------------------------------------------------------------
// polar_arbiter
//
// Shares one fixed-latency rectangular-to-polar CORDIC among NREQ sample
// sources. A round-robin arbiter issues at most one (x,y) per cycle, a tag
// pipe carries the requester id alongside the CORDIC, and returning
// (mag, phase) results are buffered in an output FIFO. Issue is limited by
// credits (in-flight + buffered <= DEPTH), so no result is ever dropped under
// downstream backpressure.
//
// Ports
//   clk          clock
//   rst          asynchronous reset, active-low
//   en           issue enable (in-flight results still drain when low)
//   req_vld      per-requester sample valid             [NREQ]
//   req_rdy      per-requester accept, one-hot or zero  [NREQ]
//   req_x/req_y  packed signed samples, requester i at [i*WIDTH +: WIDTH]
//   cor_vld      sample valid to CORDIC
//   cor_x/cor_y  sample to CORDIC
//   cor_res_vld  result valid from CORDIC (LAT cycles after cor_vld)
//   cor_mag      magnitude from CORDIC
//   cor_phase    phase from CORDIC (s3.28 radians)
//   res_vld/rdy  output handshake
//   res_mag      buffered magnitude
//   res_phase    buffered phase
//   res_id       originating requester
//   err          sticky: unexpected, overflowing or missing CORDIC result
// ---------------------------------------------------------------------------
module polar_arbiter #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4,
   parameter int LAT   = 17,
   parameter int DEPTH = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic [NREQ-1:0]                req_vld,
   output logic [NREQ-1:0]                req_rdy,
   input  logic [NREQ*WIDTH-1:0]          req_x,
   input  logic [NREQ*WIDTH-1:0]          req_y,
   output logic                           cor_vld,
   output logic signed [WIDTH-1:0]        cor_x,
   output logic signed [WIDTH-1:0]        cor_y,
   input  logic                           cor_res_vld,
   input  logic [WIDTH-1:0]               cor_mag,
   input  logic signed [31:0]             cor_phase,
   output logic                           res_vld,
   input  logic                           res_rdy,
   output logic [WIDTH-1:0]               res_mag,
   output logic signed [31:0]             res_phase,
   output logic [$clog2(NREQ)-1:0]        res_id,
   output logic                           err
);

   localparam int IDW = $clog2(NREQ);
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH + 1);

   localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
   localparam logic [AW:0]   MEM_FULL = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [IDW-1:0]            ptr_q, ptr_d;
   logic [CW-1:0]             cnt_q, cnt_d;

   logic                      cor_vld_q, cor_vld_d;
   logic signed [WIDTH-1:0]   cor_x_q, cor_x_d;
   logic signed [WIDTH-1:0]   cor_y_q, cor_y_d;
   logic [IDW-1:0]            cor_id_q, cor_id_d;

   logic [LAT-1:0]            tag_vld_q, tag_vld_d;
   logic [LAT-1:0][IDW-1:0]   tag_id_q, tag_id_d;

   logic [AW:0]               wr_ptr_q, wr_ptr_d;
   logic [AW:0]               rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0]          mem_mag   [DEPTH];
   logic signed [31:0]        mem_phase [DEPTH];
   logic [IDW-1:0]            mem_id    [DEPTH];

   logic                      res_vld_q, res_vld_d;
   logic [WIDTH-1:0]          res_mag_q, res_mag_d;
   logic signed [31:0]        res_phase_q, res_phase_d;
   logic [IDW-1:0]            res_id_q, res_id_d;
   logic                      err_q, err_d;

   // ------------------------------------------------------------------------
   // Round-robin arbitration and credit check
   // ------------------------------------------------------------------------
   logic                      found;
   logic [IDW-1:0]            win;
   logic                      credit_ok;
   logic                      issue;
   logic signed [WIDTH-1:0]   sel_x, sel_y;

   always_comb begin
      found = 1'b0;
      win   = '0;
      // Search starts one past the last winner so every requester gets a turn.
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && req_vld[(int'(ptr_q) + k) % NREQ]) begin
            found = 1'b1;
            win   = IDW'((int'(ptr_q) + k) % NREQ);
         end
      end
   end

   // Gating with rst keeps req_rdy low while the block is held in reset.
   assign credit_ok = rst & en & (cnt_q < CNT_MAX);
   assign issue     = found & credit_ok;
   assign sel_x     = req_x[win*WIDTH +: WIDTH];
   assign sel_y     = req_y[win*WIDTH +: WIDTH];

   always_comb begin
      req_rdy = '0;
      if (issue) req_rdy[win] = 1'b1;
   end

   always_comb begin
      ptr_d     = issue ? win : ptr_q;
      cor_vld_d = issue;
      cor_x_d   = issue ? sel_x : cor_x_q;
      cor_y_d   = issue ? sel_y : cor_y_q;
      cor_id_d  = issue ? win : cor_id_q;
   end

   // ------------------------------------------------------------------------
   // Tag pipe: fed from the issue register so the last stage lines up with
   // cor_res_vld exactly LAT cycles after cor_vld.
   // ------------------------------------------------------------------------
   logic                      tag_out_vld;
   logic [IDW-1:0]            tag_out_id;

   always_comb begin
      tag_vld_d[0] = cor_vld_q;
      tag_id_d[0]  = cor_id_q;
      for (int i = 1; i < LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end
   end

   assign tag_out_vld = tag_vld_q[LAT-1];
   assign tag_out_id  = tag_id_q[LAT-1];

   // ------------------------------------------------------------------------
   // Result capture and output FIFO. The output register is the FIFO head;
   // a write into an empty FIFO bypasses memory straight into it.
   // ------------------------------------------------------------------------
   logic                      mem_empty, mem_full;
   logic                      wr_en, mem_we;
   logic                      pop, out_free, lost;

   assign mem_empty = (wr_ptr_q == rd_ptr_q);
   assign mem_full  = ((wr_ptr_q - rd_ptr_q) == MEM_FULL);
   assign wr_en     = cor_res_vld & tag_out_vld & ~mem_full;
   assign pop       = res_vld_q & res_rdy;
   assign out_free  = ~res_vld_q | res_rdy;
   assign lost      = tag_out_vld & ~cor_res_vld;

   always_comb begin
      res_vld_d   = res_vld_q;
      res_mag_d   = res_mag_q;
      res_phase_d = res_phase_q;
      res_id_d    = res_id_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      mem_we      = 1'b0;
      if (out_free) begin
         if (!mem_empty) begin
            res_vld_d   = 1'b1;
            res_mag_d   = mem_mag[rd_ptr_q[AW-1:0]];
            res_phase_d = mem_phase[rd_ptr_q[AW-1:0]];
            res_id_d    = mem_id[rd_ptr_q[AW-1:0]];
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            if (wr_en) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
         end else if (wr_en) begin
            res_vld_d   = 1'b1;
            res_mag_d   = cor_mag;
            res_phase_d = cor_phase;
            res_id_d    = tag_out_id;
         end else begin
            res_vld_d   = 1'b0;
         end
      end else if (wr_en) begin
         mem_we   = 1'b1;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
   end

   // Credits: issue takes one, pop returns one, a missing result returns one.
   always_comb begin
      cnt_d = cnt_q + CW'(issue) - CW'(pop) - CW'(lost);
      err_d = err_q
            | (cor_res_vld & (~tag_out_vld | mem_full))
            | lost;
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q       <= IDW'(NREQ - 1);
         cnt_q       <= '0;
         cor_vld_q   <= 1'b0;
         cor_x_q     <= '0;
         cor_y_q     <= '0;
         cor_id_q    <= '0;
         tag_vld_q   <= '0;
         tag_id_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         res_vld_q   <= 1'b0;
         res_mag_q   <= '0;
         res_phase_q <= '0;
         res_id_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         cor_vld_q   <= cor_vld_d;
         cor_x_q     <= cor_x_d;
         cor_y_q     <= cor_y_d;
         cor_id_q    <= cor_id_d;
         tag_vld_q   <= tag_vld_d;
         tag_id_q    <= tag_id_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         res_vld_q   <= res_vld_d;
         res_mag_q   <= res_mag_d;
         res_phase_q <= res_phase_d;
         res_id_q    <= res_id_d;
         err_q       <= err_d;
      end
   end

   // FIFO storage carries data only; validity lives in the pointers.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_mag[wr_ptr_q[AW-1:0]]   <= cor_mag;
         mem_phase[wr_ptr_q[AW-1:0]] <= cor_phase;
         mem_id[wr_ptr_q[AW-1:0]]    <= tag_out_id;
      end
   end

   assign cor_vld   = cor_vld_q;
   assign cor_x     = cor_x_q;
   assign cor_y     = cor_y_q;
   assign res_vld   = res_vld_q;
   assign res_mag   = res_mag_q;
   assign res_phase = res_phase_q;
   assign res_id    = res_id_q;
   assign err       = err_q;

endmodule
